// File: rtl/if_stage_if.sv
// Instruction-memory read port of the fetch stage.
//   o_Mem_Req         request, held until accepted
//   o_Mem_Addr        read address, held until accepted
//   i_Mem_Ready       memory accepts the request this cycle
//   i_Mem_Rdata_Valid read data returned this cycle
//   i_Mem_Rdata       returned instruction word
// master = fetch stage, slave = instruction memory.
interface if_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_Mem_Req;
    logic [DATA_WIDTH-1:0] o_Mem_Addr;
    logic                  i_Mem_Ready;
    logic                  i_Mem_Rdata_Valid;
    logic [DATA_WIDTH-1:0] i_Mem_Rdata;

    modport master (
        output o_Mem_Req,
        output o_Mem_Addr,
        input  i_Mem_Ready,
        input  i_Mem_Rdata_Valid,
        input  i_Mem_Rdata
    );

    modport slave (
        input  o_Mem_Req,
        input  o_Mem_Addr,
        output i_Mem_Ready,
        output i_Mem_Rdata_Valid,
        output i_Mem_Rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, keeps at most one instruction-memory
// read outstanding, and presents {PC+4, instruction} to the IF/ID register.
// A taken branch redirects the PC and squashes any read still in flight.
//   clk, reset        core clock, synchronous active-high reset
//   i_Freeze          IF/ID will not capture this cycle
//   i_Branch_Taken    redirect fetch to i_Branch_Address
//   mem               instruction-memory read port (if_stage_if.master)
//   o_Pc              PC+4 of the delivered instruction, 0 when not valid
//   o_Instruction     delivered instruction, 0 when not valid
//   o_Valid           o_Instruction is a real fetched instruction
//
// state | meaning
// REQ   | request at pc_q on the bus, waiting for acceptance
// WAIT  | read accepted, waiting for data
// HOLD  | data received under freeze, presented from the hold buffer
// DROP  | read owed by memory was squashed by a branch, discard its data
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Freeze,
    input  logic                  i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0] i_Branch_Address,
    if_stage_if.master            mem,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic [DATA_WIDTH-1:0] o_Instruction,
    output logic                  o_Valid
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  read_owed;

    assign pc_next = pc_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        mem.o_Mem_Req  = 1'b0;
        mem.o_Mem_Addr = pc_q;
        o_Valid        = 1'b0;
        o_Pc           = '0;
        o_Instruction  = '0;
        read_owed      = 1'b0;

        unique case (state_q)
            REQ: begin
                mem.o_Mem_Req = 1'b1;
                read_owed     = mem.i_Mem_Ready;
                if (mem.i_Mem_Ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                read_owed = ~mem.i_Mem_Rdata_Valid;
                if (mem.i_Mem_Rdata_Valid) begin
                    o_Valid       = 1'b1;
                    o_Instruction = mem.i_Mem_Rdata;
                    o_Pc          = pc_next;
                    if (i_Freeze) begin
                        hold_d  = mem.i_Mem_Rdata;
                        state_d = HOLD;
                    end else begin
                        pc_d    = pc_next;
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                o_Valid       = 1'b1;
                o_Instruction = hold_q;
                o_Pc          = pc_next;
                if (!i_Freeze) begin
                    pc_d    = pc_next;
                    state_d = REQ;
                end
            end
            DROP: begin
                read_owed = ~mem.i_Mem_Rdata_Valid;
                if (mem.i_Mem_Rdata_Valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // A redirect wins over delivery and freeze. The request stays on the
        // bus this cycle, so an acceptance still leaves a read owed.
        if (i_Branch_Taken) begin
            o_Valid       = 1'b0;
            o_Pc          = '0;
            o_Instruction = '0;
            hold_d        = hold_q;
            pc_d          = i_Branch_Address;
            state_d       = read_owed ? DROP : REQ;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        freeze = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] baddr = '0;
    logic [31:0] o_pc, o_instr;
    logic        o_valid;

    if_stage_if #(.DATA_WIDTH(32)) mem_bus ();

    if_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_Freeze         (freeze),
        .i_Branch_Taken   (branch),
        .i_Branch_Address (baddr),
        .mem              (mem_bus),
        .o_Pc             (o_pc),
        .o_Instruction    (o_instr),
        .o_Valid          (o_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: fetch address, one owed read, one instruction awaiting capture.
    logic [31:0] m_pc = '0;
    bit          m_out = 0, m_squash = 0, m_have = 0;
    logic [31:0] m_inst = '0;

    // Memory model.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = '0;
    int          max_wait = 3;
    int          fixed_wait = -1;
    bit          use_data = 0;
    logic [31:0] forced_data = '0;
    bit          stale_rv = 0;

    bit          rv_now;
    logic [31:0] rdata_now;
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, exp_pc, exp_instr;

    task automatic drive(input bit f, input bit b, input logic [31:0] ba, input bit rdy);
        bit deliver_new;
        freeze = f;
        branch = b;
        baddr  = ba;
        mem_bus.i_Mem_Ready = rdy;
        rv_now    = stale_rv || (mem_busy && mem_cnt == 0);
        rdata_now = (mem_busy && mem_cnt == 0) ? mem_data : $urandom;
        mem_bus.i_Mem_Rdata_Valid = rv_now;
        mem_bus.i_Mem_Rdata       = rdata_now;
        deliver_new = rv_now && m_out && !m_squash;
        exp_req   = !m_out && !m_have;
        exp_addr  = m_pc;
        exp_valid = !b && (m_have || deliver_new);
        exp_instr = exp_valid ? (m_have ? m_inst : rdata_now) : 32'h0;
        exp_pc    = exp_valid ? m_pc + 32'd4 : 32'h0;
        #1;
    endtask

    task automatic advance();
        bit accepted, got;
        if (reset) begin
            m_pc = 32'h0; m_out = 0; m_squash = 0; m_have = 0;
            mem_busy = 0;
        end else begin
            accepted = exp_req && mem_bus.i_Mem_Ready;
            got      = rv_now && m_out;
            if (branch) begin
                if (got) m_out = 0;
                else if (m_out) m_squash = 1;
                m_have = 0;
                m_pc   = baddr;
                if (accepted) begin m_out = 1; m_squash = 1; end
            end else begin
                if (got) begin
                    m_out = 0;
                    if (!m_squash) begin m_have = 1; m_inst = rdata_now; end
                end
                if (accepted) begin m_out = 1; m_squash = 0; end
                if (m_have && !freeze) begin m_pc = m_pc + 32'd4; m_have = 0; end
            end
            if (mem_busy && mem_cnt == 0) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (accepted) begin
                mem_busy = 1;
                mem_cnt  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
                mem_data = use_data ? forced_data : $urandom;
                use_data = 0;
            end
        end
        stale_rv = 0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 32'h0, 0);
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        drive(0, 0, 32'h0, 0);
        n_cmp += 5;
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL reset_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", mem_bus.o_Mem_Addr); end
        if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
        if (o_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h want=0", o_pc); end
        if (o_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h want=0", o_instr); end
        advance();
    endtask

    task automatic test_zero_wait();
        do_reset(2);
        fixed_wait = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 32'h0, 1);
            n_cmp += 2;
            if (mem_bus.o_Mem_Req !== (k % 2 == 0)) begin
                n_bad++; $display("FAIL zw_req k=%0d got=%0b want=%0b", k, mem_bus.o_Mem_Req, (k % 2 == 0));
            end
            if (o_valid !== (k % 2 == 1)) begin
                n_bad++; $display("FAIL zw_valid k=%0d got=%0b want=%0b", k, o_valid, (k % 2 == 1));
            end
            n_cmp++;
            if (k % 2 == 0) begin
                if (mem_bus.o_Mem_Addr !== 32'(k / 2 * 4)) begin
                    n_bad++; $display("FAIL zw_addr k=%0d got=%h want=%h", k, mem_bus.o_Mem_Addr, 32'(k / 2 * 4));
                end
            end else begin
                if (o_pc !== 32'((k / 2 + 1) * 4)) begin
                    n_bad++; $display("FAIL zw_pc k=%0d got=%h want=%h", k, o_pc, 32'((k / 2 + 1) * 4));
                end
            end
            advance();
        end
        fixed_wait = -1;
    endtask

    task automatic test_freeze_hold();
        do_reset(1);
        fixed_wait = 0; use_data = 1; forced_data = 32'hE3A01005;
        drive(0, 0, 32'h0, 1);
        advance();
        for (int k = 1; k <= 4; k++) begin
            drive(k < 4, 0, 32'h0, 0);
            n_cmp += 4;
            if (o_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid k=%0d got=%0b want=1", k, o_valid); end
            if (o_instr !== 32'hE3A01005) begin n_bad++; $display("FAIL hold_instr k=%0d got=%h want=e3a01005", k, o_instr); end
            if (o_pc !== 32'h4) begin n_bad++; $display("FAIL hold_pc k=%0d got=%h want=4", k, o_pc); end
            if (mem_bus.o_Mem_Req !== 1'b0) begin n_bad++; $display("FAIL hold_req k=%0d got=%0b want=0", k, mem_bus.o_Mem_Req); end
            advance();
        end
        drive(0, 0, 32'h0, 0);
        n_cmp += 2;
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL hold_next_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h4) begin n_bad++; $display("FAIL hold_next_addr got=%h want=4", mem_bus.o_Mem_Addr); end
        advance();
        fixed_wait = -1;
    endtask

    task automatic test_branch_wait();
        do_reset(1);
        fixed_wait = 2;
        drive(0, 0, 32'h0, 1);
        advance();
        for (int k = 1; k <= 3; k++) begin
            drive(0, k == 1, 32'h100, 1);
            n_cmp += 2;
            if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bw_valid k=%0d got=%0b want=0", k, o_valid); end
            if (mem_bus.o_Mem_Req !== 1'b0) begin n_bad++; $display("FAIL bw_req k=%0d got=%0b want=0", k, mem_bus.o_Mem_Req); end
            advance();
        end
        drive(0, 0, 32'h0, 0);
        n_cmp += 2;
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL bw_next_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h100) begin n_bad++; $display("FAIL bw_next_addr got=%h want=100", mem_bus.o_Mem_Addr); end
        advance();
        fixed_wait = -1;
    endtask

    task automatic test_branch_same();
        do_reset(1);
        fixed_wait = 0;
        drive(0, 0, 32'h0, 1);
        advance();
        drive(0, 1, 32'h100, 0);
        n_cmp += 3;
        if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bs_valid got=%0b want=0", o_valid); end
        if (o_pc !== 32'h0) begin n_bad++; $display("FAIL bs_pc got=%h want=0", o_pc); end
        if (o_instr !== 32'h0) begin n_bad++; $display("FAIL bs_instr got=%h want=0", o_instr); end
        advance();
        drive(0, 0, 32'h0, 0);
        n_cmp += 2;
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL bs_next_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h100) begin n_bad++; $display("FAIL bs_next_addr got=%h want=100", mem_bus.o_Mem_Addr); end
        advance();
        fixed_wait = -1;
    endtask

    task automatic test_reset_midwait();
        do_reset(1);
        fixed_wait = 5;
        drive(0, 0, 32'h0, 1);
        advance();
        drive(0, 0, 32'h0, 0);
        advance();
        do_reset(1);
        stale_rv = 1; fixed_wait = 0; use_data = 1; forced_data = 32'hCAFEF00D;
        drive(0, 0, 32'h0, 1);
        n_cmp += 3;
        if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmw_stale_valid got=%0b want=0", o_valid); end
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL rmw_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h0) begin n_bad++; $display("FAIL rmw_addr got=%h want=0", mem_bus.o_Mem_Addr); end
        advance();
        drive(0, 0, 32'h0, 0);
        n_cmp += 3;
        if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rmw_valid got=%0b want=1", o_valid); end
        if (o_instr !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rmw_instr got=%h want=cafef00d", o_instr); end
        if (o_pc !== 32'h4) begin n_bad++; $display("FAIL rmw_pc got=%h want=4", o_pc); end
        advance();
        fixed_wait = -1;
    endtask

    task automatic test_wrap();
        do_reset(1);
        drive(0, 1, 32'hFFFFFFFC, 0);
        advance();
        fixed_wait = 0;
        drive(0, 0, 32'h0, 1);
        n_cmp++;
        if (mem_bus.o_Mem_Addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_addr got=%h want=fffffffc", mem_bus.o_Mem_Addr); end
        advance();
        drive(0, 0, 32'h0, 0);
        n_cmp += 2;
        if (o_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got=%0b want=1", o_valid); end
        if (o_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got=%h want=0", o_pc); end
        advance();
        drive(0, 0, 32'h0, 0);
        n_cmp += 2;
        if (mem_bus.o_Mem_Req !== 1'b1) begin n_bad++; $display("FAIL wrap_next_req got=%0b want=1", mem_bus.o_Mem_Req); end
        if (mem_bus.o_Mem_Addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next_addr got=%h want=0", mem_bus.o_Mem_Addr); end
        advance();
        fixed_wait = -1;
    endtask

    task automatic test_random();
        bit          f, b, rdy;
        logic [31:0] ba;
        do_reset(2);
        max_wait = 3;
        for (int c = 0; c < 3000; c++) begin
            f   = ($urandom % 3) == 0;
            b   = ($urandom % 12) == 0;
            rdy = ($urandom % 2) == 0;
            ba  = (($urandom % 4) == 0) ? (32'hFFFFFFF0 + {$urandom_range(0, 3), 2'b00})
                                        : {$urandom, 2'b00};
            drive(f, b, ba, rdy);
            n_cmp += 4;
            if (mem_bus.o_Mem_Req !== exp_req) begin
                n_bad++; $display("FAIL rnd_req c=%0d got=%0b want=%0b", c, mem_bus.o_Mem_Req, exp_req);
            end
            if (o_valid !== exp_valid) begin
                n_bad++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, o_valid, exp_valid);
            end
            if (o_pc !== exp_pc) begin
                n_bad++; $display("FAIL rnd_pc c=%0d got=%h want=%h", c, o_pc, exp_pc);
            end
            if (o_instr !== exp_instr) begin
                n_bad++; $display("FAIL rnd_instr c=%0d got=%h want=%h", c, o_instr, exp_instr);
            end
            if (exp_req) begin
                n_cmp++;
                if (mem_bus.o_Mem_Addr !== exp_addr) begin
                    n_bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, mem_bus.o_Mem_Addr, exp_addr);
                end
            end
            advance();
        end
    endtask

    initial begin
        mem_bus.i_Mem_Ready       = 1'b0;
        mem_bus.i_Mem_Rdata_Valid = 1'b0;
        mem_bus.i_Mem_Rdata       = '0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_freeze_hold();
        test_branch_wait();
        test_branch_same();
        test_reset_midwait();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
